// File: rtl/drone_dispatch.sv
// drone_dispatch: drop-point controller for a vertical shaft with N_DEST stops.
// Latches calls, serves them in SCAN (elevator) order and holds a one-hot drop
// command until the drop sensor confirms or the drop window times out.
module drone_dispatch #(
    parameter int N_DEST       = 4,
    parameter int DROP_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_DEST-1:0]         Floor,
    input  logic [N_DEST-1:0]         FS,
    input  logic [N_DEST-1:0]         Call,
    output logic [1:0]                Motor,
    output logic [N_DEST-1:0]         Drop,
    output logic [N_DEST-1:0]         Pending,
    output logic [$clog2(N_DEST)-1:0] Pos,
    output logic                      Fault
);
    localparam int PW = $clog2(N_DEST);
    localparam int TW = $clog2(DROP_TIMEOUT);
    localparam logic [TW-1:0]     T_LAST  = TW'(DROP_TIMEOUT - 1);
    localparam logic [PW-1:0]     IDX_TOP = PW'(N_DEST - 1);
    localparam logic [N_DEST-1:0] ONE     = N_DEST'(1);
    localparam logic [1:0]        M_UP    = 2'b10;
    localparam logic [1:0]        M_DN    = 2'b01;
    localparam logic [1:0]        M_HOVER = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DROP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_dir;          // 1 = up
    logic [PW-1:0]   r_tgt;
    logic [TW-1:0]   r_timer;

    logic            w_floor_valid;
    logic [PW-1:0]   w_floor_idx;
    logic            w_docked;
    logic            w_at_end;
    logic            w_up_found;
    logic            w_dn_found;
    logic            w_tgt_found;
    logic            w_tgt_up;

    logic [1:0]        w_motor_nxt;
    logic [N_DEST-1:0] w_drop_nxt;
    logic [N_DEST-1:0] w_clr;
    logic              w_fault_nxt;
    logic [PW-1:0]     w_tgt_nxt;
    logic              w_dir_nxt;
    logic [TW-1:0]     w_timer_nxt;

    // A multi-hot reading is treated the same as in transit.
    assign w_floor_valid = $onehot(Floor);
    assign w_docked      = w_floor_valid && (w_floor_idx == Pos);
    // Reaching the last stop in the travel direction with nothing to serve ends the run.
    assign w_at_end      = w_floor_valid && (r_dir ? (w_floor_idx == IDX_TOP) : (w_floor_idx == '0));

    // Decode the index of the set Floor bit (only meaningful when one-hot).
    always_comb begin
        w_floor_idx = '0;
        for (int i = 0; i < N_DEST; i++)
            if (Floor[i]) w_floor_idx = PW'(i);
    end

    // Look for any pending stop strictly above and strictly below the last position.
    always_comb begin
        w_up_found = 1'b0;
        w_dn_found = 1'b0;
        for (int i = 0; i < N_DEST; i++) begin
            if (Pending[i] && (i > int'(Pos))) w_up_found = 1'b1;
            if (Pending[i] && (i < int'(Pos))) w_dn_found = 1'b1;
        end
    end

    // SCAN choice: keep going the current way if anything is ahead, else reverse.
    always_comb begin
        w_tgt_found = 1'b0;
        w_tgt_up    = r_dir;
        if (r_dir) begin
            if (w_up_found)      begin w_tgt_found = 1'b1; w_tgt_up = 1'b1; end
            else if (w_dn_found) begin w_tgt_found = 1'b1; w_tgt_up = 1'b0; end
        end else begin
            if (w_dn_found)      begin w_tgt_found = 1'b1; w_tgt_up = 1'b0; end
            else if (w_up_found) begin w_tgt_found = 1'b1; w_tgt_up = 1'b1; end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_docked && Pending[Pos]) w_state_nxt = S_DROP;
                else if (w_tgt_found)         w_state_nxt = S_MOVE;
            end
            S_MOVE: begin
                // Stopping at any pending stop we dock at picks up calls made en route.
                if (w_floor_valid && Pending[w_floor_idx]) w_state_nxt = S_DROP;
                else if (w_at_end)                         w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (FS[r_tgt] || (r_timer == T_LAST)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and datapath.
    always_comb begin
        w_motor_nxt = Motor;
        w_drop_nxt  = Drop;
        w_clr       = '0;
        w_fault_nxt = Fault;
        w_tgt_nxt   = r_tgt;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        unique case (r_state)
            S_IDLE: begin
                // IDLE always hovers, so a reversal costs at least one hover cycle.
                w_motor_nxt = M_HOVER;
                w_drop_nxt  = '0;
                if (w_docked && Pending[Pos]) begin
                    w_tgt_nxt   = Pos;
                    w_drop_nxt  = ONE << Pos;
                    w_timer_nxt = '0;
                end else if (w_tgt_found) begin
                    w_dir_nxt   = w_tgt_up;
                    w_motor_nxt = w_tgt_up ? M_UP : M_DN;
                end
            end
            S_MOVE: begin
                if (w_floor_valid && Pending[w_floor_idx]) begin
                    w_motor_nxt = M_HOVER;
                    w_tgt_nxt   = w_floor_idx;
                    w_drop_nxt  = ONE << w_floor_idx;
                    w_timer_nxt = '0;
                end else if (w_at_end) begin
                    w_motor_nxt = M_HOVER;
                end
            end
            S_DROP: begin
                w_motor_nxt = M_HOVER;
                if (FS[r_tgt]) begin
                    w_drop_nxt = '0;
                    w_clr      = ONE << r_tgt;
                end else if (r_timer == T_LAST) begin
                    // Abandon the stop: it must be called again to be served.
                    w_drop_nxt  = '0;
                    w_clr       = ONE << r_tgt;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_motor_nxt = M_HOVER;
                w_drop_nxt  = '0;
            end
        endcase
    end

    // Registered outputs, request latch and position tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Motor   <= M_HOVER;
            Drop    <= '0;
            Pending <= '0;
            Pos     <= '0;
            Fault   <= 1'b0;
            r_dir   <= 1'b1;
            r_tgt   <= '0;
            r_timer <= '0;
        end else begin
            Motor   <= w_motor_nxt;
            Drop    <= w_drop_nxt;
            // A new call on the bit being cleared wins, so the delivery repeats.
            Pending <= (Pending & ~w_clr) | Call;
            if (w_floor_valid) Pos <= w_floor_idx;
            Fault   <= w_fault_nxt;
            r_dir   <= w_dir_nxt;
            r_tgt   <= w_tgt_nxt;
            r_timer <= w_timer_nxt;
        end
    end

endmodule

// File: tb/tb_drone_dispatch.sv
// tb_drone_dispatch: shaft plant + drop-sensor responder + scoreboard monitor.
// Expected deliveries come from a SCAN ordering of each call batch.
module tb_drone_dispatch;
    localparam int N   = 4;
    localparam int TMO = 16;

    typedef struct {
        int dest;
        bit timeout;
        int r;
        bit pend_after;
        bit recall;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] Floor, FS, Call, call_main, call_rsp;
    logic [1:0]   Motor;
    logic [N-1:0] Drop, Pending;
    logic [1:0]   Pos;
    logic         Fault;

    entry_t sb_q[$];
    entry_t rsp_q[$];
    int     ord_q[$];
    int     n_chk = 0;
    int     n_err = 0;
    int     pos2;
    bit     model_dir;
    bit     model_fault;
    bit     mon_in_drop;

    assign Call = call_main | call_rsp;

    drone_dispatch #(.N_DEST(N), .DROP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .Floor(Floor), .FS(FS), .Call(Call),
        .Motor(Motor), .Drop(Drop), .Pending(Pending), .Pos(Pos), .Fault(Fault)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // SCAN order from stop p: p itself, then stops ahead nearest-first, then the rest.
    task automatic scan_order(input int p, input logic [N-1:0] s);
        int ahead[$];
        int behind[$];
        ord_q.delete();
        if (s[p]) ord_q.push_back(p);
        for (int k = 1; k < N; k++) begin
            int a;
            int b;
            a = model_dir ? p + k : p - k;
            b = model_dir ? p - k : p + k;
            if (a >= 0 && a < N && s[a]) ahead.push_back(a);
            if (b >= 0 && b < N && s[b]) behind.push_back(b);
        end
        foreach (ahead[i])  ord_q.push_back(ahead[i]);
        foreach (behind[i]) ord_q.push_back(behind[i]);
        if (behind.size() > 0) model_dir = !model_dir;
    endtask

    task automatic plan(input logic [N-1:0] s, input int to_pct, input bit recall);
        entry_t e;
        scan_order(pos2 / 2, s);
        foreach (ord_q[i]) begin
            e.dest       = ord_q[i];
            e.timeout    = ($urandom_range(99) < to_pct);
            e.r          = $urandom_range(4);
            e.pend_after = recall;
            e.recall     = recall;
            sb_q.push_back(e);
            rsp_q.push_back(e);
            if (recall) begin
                e.pend_after = 0;
                e.recall     = 0;
                e.r          = $urandom_range(4);
                sb_q.push_back(e);
                rsp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_call(input logic [N-1:0] s);
        call_main = s;
        @(negedge clk);
        call_main = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && !mon_in_drop && Motor == 2'b00 && Drop == '0
                 && Pending == '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk({tag, "_timeout"}, sb_q.size(), 0);
        repeat (2) @(negedge clk);
        chk({tag, "_pending_empty"}, int'(Pending), 0);
        chk({tag, "_pos"}, int'(Pos), pos2 / 2);
    endtask

    // Shaft plant: two cycles per half-step, even half-steps are docked stops.
    initial begin
        int sub;
        sub   = 0;
        pos2  = 0;
        Floor = oh(0);
        forever begin
            @(negedge clk);
            if (Motor == 2'b10 || Motor == 2'b01) begin
                sub++;
                if (sub >= 2) begin
                    sub = 0;
                    if (Motor == 2'b10 && pos2 < 2 * (N - 1)) pos2++;
                    else if (Motor == 2'b01 && pos2 > 0) pos2--;
                end
            end else begin
                sub = 0;
            end
            Floor = (pos2 % 2 == 0) ? oh(pos2 / 2) : '0;
        end
    end

    // Drop-sensor responder: confirms after r cycles, or never for a timeout entry.
    initial begin
        entry_t       e;
        logic [N-1:0] pd;
        pd       = '0;
        FS       = '0;
        call_rsp = '0;
        forever begin
            @(negedge clk);
            if (!rst && Drop != '0 && pd == '0 && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                if (e.timeout) begin
                    while (Drop != '0 && !rst) begin
                        FS = N'($urandom) & ~oh(e.dest);
                        @(negedge clk);
                    end
                    FS = '0;
                end else begin
                    for (int k = 0; k < e.r; k++) begin
                        FS = N'($urandom) & ~oh(e.dest);
                        @(negedge clk);
                    end
                    FS       = oh(e.dest) | (N'($urandom) & ~oh(e.dest));
                    call_rsp = e.recall ? oh(e.dest) : '0;
                    @(negedge clk);
                    FS       = '0;
                    call_rsp = '0;
                end
            end
            pd = Drop;
        end
    end

    // Monitor: pops an expected delivery on every Drop rise and checks it on the fall.
    initial begin
        entry_t     cur;
        int         dur;
        logic [1:0] pm;
        bit         fchk;
        dur         = 0;
        pm          = 2'b00;
        fchk        = 0;
        mon_in_drop = 0;
        cur         = '{dest: 0, timeout: 0, r: 0, pend_after: 0, recall: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_in_drop = 0;
                fchk        = 0;
                pm          = 2'b00;
                continue;
            end
            if (fchk) begin
                chk("fault_flag", int'(Fault), int'(model_fault));
                fchk = 0;
            end
            if (Motor == 2'b11) chk("motor_code_11", 1, 0);
            if (Motor != pm && Motor != 2'b00) chk("hover_before_motion", int'(pm), 0);
            pm = Motor;
            if (!mon_in_drop && Drop != '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_drop", int'(Drop), 0);
                    cur = '{dest: 0, timeout: 0, r: 0, pend_after: 0, recall: 0};
                end else begin
                    cur = sb_q.pop_front();
                    chk("drop_dest", int'(Drop), int'(oh(cur.dest)));
                    chk("motor_in_drop", int'(Motor), 0);
                end
                mon_in_drop = 1;
                dur         = 1;
            end else if (mon_in_drop && Drop != '0) begin
                dur++;
            end else if (mon_in_drop) begin
                mon_in_drop = 0;
                chk("drop_len", dur, cur.timeout ? TMO : cur.r + 1);
                chk("pending_after_drop", int'(Pending[cur.dest]), int'(cur.pend_after));
                if (cur.timeout) model_fault = 1;
                fchk = 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        entry_t e;
        rst         = 1'b1;
        call_main   = '0;
        model_dir   = 1;
        model_fault = 0;
        repeat (3) @(negedge clk);
        chk("rst_motor",   int'(Motor),   0);
        chk("rst_drop",    int'(Drop),    0);
        chk("rst_pending", int'(Pending), 0);
        chk("rst_pos",     int'(Pos),     0);
        chk("rst_fault",   int'(Fault),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single delivery 0 -> 2 with motor latency.
        plan(4'b0100, 0, 0);
        pulse_call(4'b0100);
        chk("motor_before_latency", int'(Motor), 0);
        @(negedge clk);
        chk("motor_up_after_latency", int'(Motor), 2);
        wait_idle("single");

        // Reposition to 0 then 1 (ends at 1 heading up), then SCAN {0,3}.
        plan(4'b0001, 0, 0);
        pulse_call(4'b0001);
        wait_idle("to0");
        plan(4'b0010, 0, 0);
        pulse_call(4'b0010);
        wait_idle("to1");
        plan(4'b1001, 0, 0);
        pulse_call(4'b1001);
        wait_idle("scan");

        // Pick-up en route: heading to 3, call 2 while passing 1.
        plan(4'b1100, 0, 0);
        pulse_call(4'b1000);
        n = 0;
        while (pos2 != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pickup_reach_1", pos2, 2);
        pulse_call(4'b0100);
        wait_idle("pickup");

        // Drop timeout at 2.
        plan(4'b0100, 100, 0);
        pulse_call(4'b0100);
        wait_idle("timeout");
        chk("fault_sticky", int'(Fault), 1);

        // Same-cycle set and clear at 1: delivered twice without moving.
        plan(4'b0010, 0, 1);
        pulse_call(4'b0010);
        wait_idle("set_clr");

        // Reset in the middle of a drop at 2.
        e = '{dest: 2, timeout: 1, r: 0, pend_after: 0, recall: 0};
        sb_q.push_back(e);
        rsp_q.push_back(e);
        pulse_call(4'b0100);
        n = 0;
        while (Drop == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_drop_drop", int'(Drop), 4);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_drop",  int'(Drop),  0);
        chk("async_rst_motor", int'(Motor), 0);
        @(negedge clk);
        chk("rst_drop_pending", int'(Pending), 0);
        chk("rst_drop_fault",   int'(Fault),   0);
        chk("rst_drop_pos",     int'(Pos),     0);
        rst = 1'b0;
        sb_q.delete();
        rsp_q.delete();
        model_fault = 0;
        model_dir   = 1;
        repeat (3) @(negedge clk);
        chk("pos_resync", int'(Pos), pos2 / 2);

        // Randomised call batches.
        for (int b = 0; b < 25; b++) begin
            logic [N-1:0] s;
            s = N'($urandom_range(15, 1));
            plan(s, 15, 0);
            pulse_call(s);
            wait_idle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
